nios2_oci_trace_monitor: RTL
============================

Name: nios2_oci_trace_monitor

Overview:
- Parametrised successor to the OCI test-bench sink.
- Instead of discarding the debug-control-trace (DCT) stream, it captures {dct_count, dct_buffer} entries into a circular buffer during a test.
- On test end it drains them over a ready/valid port and flags protocol and overflow errors.
- Sits beside the Nios2 OCI block in simulation and lab-capture builds; it is fully synthesisable.

Parameters:
- DCT_W, 30, width of dct_buffer.
- CNT_W, 4, width of dct_count.
- DEPTH, 16, buffer entries; power of two, >= 2.
- WRAP, 1, full policy: 1 = overwrite oldest entry, 0 = drop newest entry.
- DROP_W, 16, width of the saturating dropped-entry counter.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- dct_valid  in  1  qualifies dct_buffer/dct_count this cycle.
- dct_buffer  in  DCT_W  trace payload.
- dct_count  in  CNT_W  valid-word count tag; 0 = empty entry.
- test_ending  in  1  test-ending pulse or level.
- test_has_ended  in  1  test-complete indication.
- rd_ready  in  1  consumer accepts rd_data.
- rd_valid  out  1  rd_data holds the oldest unread entry.
- rd_data  out  CNT_W+DCT_W  {dct_count, dct_buffer} of the oldest entry.
- occupancy  out  $clog2(DEPTH)+1  entries currently held.
- overflow  out  1  sticky: at least one entry was lost.
- dropped_cnt  out  DROP_W  lost entries, saturating at all-ones.
- seq_err  out  1  sticky: test_has_ended seen before test_ending.
- done  out  1  drain complete.

Behaviour:
- Reset
  - Synchronous reset is honoured in any state, including mid-drain.
  - State goes to IDLE; pointers and occupancy clear to 0.
  - All outputs are 0; buffer contents become don't-care.
- States: IDLE, CAPTURE, DRAIN, DONE.
- IDLE
  - An accepted entry moves the block to CAPTURE; that entry is written in the same cycle.
  - test_ending or test_has_ended moves the block directly to DRAIN.
- Accepted entry
  - Condition: dct_valid=1 && dct_count!=0 while in IDLE or CAPTURE.
  - Entries with dct_count==0 are ignored and not counted as dropped.
- Write
  - Entry goes to mem[wr_ptr]; wr_ptr increments modulo DEPTH; occupancy increments.
- Full (occupancy==DEPTH) with an accepted entry:
  - WRAP=1: write proceeds and rd_ptr advances in the same cycle. Occupancy stays DEPTH; the oldest entry is lost.
  - WRAP=0: the entry is discarded; pointers are unchanged.
  - Both modes: overflow<=1 and dropped_cnt increments by 1, holding once it reaches all-ones.
- CAPTURE -> DRAIN
  - Taken on test_ending=1.
  - An accepted entry in that same cycle is still written.
- Sequencing error
  - test_has_ended=1 in IDLE or CAPTURE before any test_ending: seq_err<=1 and the block enters DRAIN.
  - A same-cycle entry is still written.
- Sticky ended flag
  - ended_seen is set whenever test_has_ended=1 in any state except DONE.
- DRAIN
  - dct_valid is ignored.
  - rd_valid = (occupancy!=0); rd_data = mem[rd_ptr], registered.
  - First rd_valid appears exactly 1 cycle after entering DRAIN.
  - Pop on rd_valid && rd_ready: rd_ptr increments, occupancy decrements, and the next entry is valid the following cycle (throughput 1 entry/cycle).
  - rd_data is held stable while rd_valid && !rd_ready.
- DRAIN -> DONE
  - Taken when occupancy==0 && ended_seen.
  - If the buffer is empty but test_has_ended is not yet seen, the block waits in DRAIN with rd_valid=0.
- DONE
  - done=1, rd_valid=0; all status outputs are held until reset.
- Pointer arithmetic
  - Pointers are $clog2(DEPTH) bits with natural wrap.
  - Occupancy is one bit wider so full and empty are unambiguous.

Decomposition:
- Package nios2_oci_tb_pkg holds:
  - the state enum (IDLE=2'd0, CAPTURE=2'd1, DRAIN=2'd2, DONE=2'd3);
  - the entry-width localparam helper (CNT_W+DCT_W);
  - the saturating-increment function.
- One sub-module: nios2_oci_trace_ring.
  - Contains the DEPTH x entry memory, pointers, occupancy, and overwrite/drop logic.
  - Interface: push, pop, wrap mode, full, empty, dropped pulse.
- The top level holds the FSM, sticky flags, and dropped counter.

Test Plan:
- Basic capture and drain (defaults):
  - Stimulus: push 5 entries with counts 1..5 and buffer 0x0000_00A0+i; pulse test_ending; hold test_has_ended=1; rd_ready=1.
  - Required: rd_data {i, 0x0000_00A0+i} in order, rd_valid first seen 1 cycle after DRAIN entry; done=1; overflow=0.
- Wrap overflow (WRAP=1, DEPTH=16):
  - Stimulus: push 20 entries tagged 0..19.
  - Required: drain returns entries 4..19; dropped_cnt=4; overflow=1; occupancy peaks at 16.
- Drop overflow (WRAP=0):
  - Stimulus: same 20 pushes.
  - Required: drain returns 0..15; dropped_cnt=4.
- Backpressure and zero-count filter:
  - Stimulus: include 3 entries with dct_count=0; toggle rd_ready 1-0-1 each cycle.
  - Required: zero-count entries absent and not counted as dropped; rd_data stable while rd_ready=0; no entry lost or duplicated.
- Sequencing error and wait:
  - Stimulus: test_has_ended=1 with no prior test_ending after 2 entries.
  - Required: seq_err=1; both entries drained; done=1.
  - Separately: test_ending with empty buffer and no test_has_ended keeps the block in DRAIN with done=0 until test_has_ended=1.
- Reset mid-drain:
  - Stimulus: assert reset for 1 cycle after 2 of 8 pops.
  - Required: next cycle state IDLE; occupancy=0; rd_valid=0; overflow, seq_err, done and dropped_cnt all 0.

Source files
------------

// File: rtl/nios2_oci_tb_pkg.sv
// Shared types and helpers for the OCI trace monitor: FSM encoding,
// entry-width helper and saturating increment.
package nios2_oci_tb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_e;

    // Width of one stored entry, {dct_count, dct_buffer}.
    function automatic int entry_width(input int cnt_w, input int dct_w);
        return cnt_w + dct_w;
    endfunction

    // Increment that sticks at all-ones of the given width (width <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/nios2_oci_trace_ring.sv
// Circular entry buffer with overwrite-oldest or drop-newest full policy.
// The controller never pushes and pops in the same cycle; push wins if it does.
module nios2_oci_trace_ring
    import nios2_oci_tb_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int ENTRY_W = 34
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       push_data,
    input  logic                     pop,
    input  logic                     wrap,
    output logic                     full,
    output logic                     empty,
    output logic                     dropped,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [ENTRY_W-1:0]       peek_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   rd_ptr_nxt;
    logic               do_write;
    logic               do_pop;
    logic               overwrite;

    assign full      = (occupancy == OCC_W'(DEPTH));
    assign empty     = (occupancy == '0);
    assign do_write  = push && (!full || wrap);
    assign overwrite = push && full && wrap;
    assign dropped   = push && full;
    assign do_pop    = pop && !push && !empty;

    assign rd_ptr_nxt = rd_ptr + PTR_W'(do_pop || overwrite);
    // Look-ahead read so the registered rd_data upstream tracks a pop in the same edge.
    assign peek_data  = mem[rd_ptr_nxt];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, whatever the block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr <= rd_ptr_nxt;
            if (do_write && !full) occupancy <= occupancy + OCC_W'(1);
            else if (do_pop)       occupancy <= occupancy - OCC_W'(1);
        end
    end

    // NOTE: the storage array is deliberately left out of reset; pointers and
    // occupancy define what is valid, so clearing it would only cost logic.
    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/nios2_oci_trace_monitor.sv
// Captures the OCI debug-control-trace stream into a ring during a test and
// drains it over a ready/valid port afterwards, flagging sequencing and overflow errors.
module nios2_oci_trace_monitor
    import nios2_oci_tb_pkg::*;
#(
    parameter int DCT_W  = 30,
    parameter int CNT_W  = 4,
    parameter int DEPTH  = 16,
    parameter bit WRAP   = 1'b1,
    parameter int DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dct_valid,
    input  logic [DCT_W-1:0]         dct_buffer,
    input  logic [CNT_W-1:0]         dct_count,
    input  logic                     test_ending,
    input  logic                     test_has_ended,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [CNT_W+DCT_W-1:0]   rd_data,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     overflow,
    output logic [DROP_W-1:0]        dropped_cnt,
    output logic                     seq_err,
    output logic                     done
);

    localparam int ENTRY_W = entry_width(CNT_W, DCT_W);
    localparam int OCC_W   = $clog2(DEPTH) + 1;

    state_e             state;
    state_e             state_nxt;
    logic               ended_seen;
    logic               capturing;
    logic               accept;
    logic               pop;
    logic               ring_full;
    logic               ring_empty;
    logic               ring_dropped;
    logic [ENTRY_W-1:0] peek_data;
    logic [OCC_W-1:0]   occ_after;

    assign capturing = (state == IDLE) || (state == CAPTURE);
    assign accept    = capturing && dct_valid && (dct_count != '0);
    assign pop       = (state == DRAIN) && rd_valid && rd_ready;
    assign occ_after = occupancy - OCC_W'(pop);
    assign done      = (state == DONE);

    nios2_oci_trace_ring #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_ring (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data ({dct_count, dct_buffer}),
        .pop       (pop),
        .wrap      (WRAP),
        .full      (ring_full),
        .empty     (ring_empty),
        .dropped   (ring_dropped),
        .occupancy (occupancy),
        .peek_data (peek_data)
    );

    // NOTE: state_nxt is given its default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (test_ending || test_has_ended) state_nxt = DRAIN;
                else if (accept)                   state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (test_ending || test_has_ended) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (ring_empty && ended_seen) state_nxt = DONE;
            end
            DONE: state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ended_seen  <= 1'b0;
            seq_err     <= 1'b0;
            overflow    <= 1'b0;
            dropped_cnt <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
        end else begin
            state <= state_nxt;
            if (test_has_ended && state != DONE) ended_seen <= 1'b1;
            // Test reported complete without ever announcing its end.
            if (capturing && test_has_ended && !test_ending) seq_err <= 1'b1;
            if (accept && ring_full) overflow <= 1'b1;
            if (ring_dropped) dropped_cnt <= DROP_W'(sat_inc(32'(dropped_cnt), DROP_W));
            if (state == DRAIN) begin
                rd_valid <= (occ_after != '0);
                rd_data  <= peek_data;
            end else begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule
